// File: rtl/eth_pkg.sv
// eth_pkg
// Shared definitions for the 10G uplink path. The grant-state encoding lives
// here so the uplink scheduler and the MAC glue logic decode o_grant the same
// way, together with the default AXI-Stream widths of the 10G TX datapath.
//
// Contents:
//   ETH_DATA_W / ETH_KEEP_W   default tdata / tkeep widths
//   GRANT_NONE/CTRL/DATA      owner encoding reported on o_grant
//   grant_state_e             scheduler FSM states (value == grant encoding)
package eth_pkg;

    localparam int ETH_DATA_W = 64;
    localparam int ETH_KEEP_W = ETH_DATA_W / 8;

    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_CTRL = 2'd1;
    localparam logic [1:0] GRANT_DATA = 2'd2;

    // The FSM state doubles as the externally visible owner code.
    typedef enum logic [1:0] {
        ST_IDLE = GRANT_NONE,
        ST_CTRL = GRANT_CTRL,
        ST_DATA = GRANT_DATA
    } grant_state_e;

endpackage

// File: rtl/axis_skid_reg.sv
// axis_skid_reg
// Two-entry AXI-Stream register slice (skid buffer) carrying data, keep,
// last and user. Sustains one beat per cycle; s_tready is a register so
// there is no combinational path from m_tready back to the source.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   s_tvalid/tdata/tkeep/tlast/tuser input beat
//   s_tready                         registered "skid entry empty"
//   m_tvalid/tdata/tkeep/tlast/tuser registered output beat
//   m_tready                         downstream backpressure
module axis_skid_reg
    import eth_pkg::*;
#(
    parameter int DATA_W = ETH_DATA_W,
    parameter int KEEP_W = ETH_KEEP_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tlast,
    input  logic              s_tuser,
    output logic              s_tready,
    output logic              m_tvalid,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tlast,
    output logic              m_tuser,
    input  logic              m_tready
);

    localparam int PAY_W = DATA_W + KEEP_W + 2;

    logic [PAY_W-1:0] s_pay;
    logic [PAY_W-1:0] out_pay_q, out_pay_d;
    logic [PAY_W-1:0] skid_pay_q, skid_pay_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             s_ready_q;
    logic             out_free;
    logic             s_fire;

    assign s_pay = {s_tdata, s_tkeep, s_tlast, s_tuser};

    // The output register refills from the skid entry first so beat order is
    // kept. A beat accepted while the output is stalled parks in the skid
    // entry; s_tready was already high that cycle, which is why a second
    // entry is needed at all. Once the skid entry is occupied s_tready drops,
    // so an accept and a skid drain can never collide.
    always_comb begin
        out_free     = ~out_valid_q | m_tready;
        s_fire       = s_tvalid & s_ready_q;
        out_valid_d  = out_valid_q;
        out_pay_d    = out_pay_q;
        skid_valid_d = skid_valid_q;
        skid_pay_d   = skid_pay_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pay_d    = skid_pay_q;
                skid_valid_d = 1'b0;
            end else if (s_fire) begin
                out_valid_d = 1'b1;
                out_pay_d   = s_pay;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (s_fire) begin
            skid_valid_d = 1'b1;
            skid_pay_d   = s_pay;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_q  <= 1'b0;
            out_pay_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_pay_q   <= '0;
            s_ready_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pay_q    <= out_pay_d;
            skid_valid_q <= skid_valid_d;
            skid_pay_q   <= skid_pay_d;
            s_ready_q    <= ~skid_valid_d;
        end
    end

    assign s_tready = s_ready_q;
    assign m_tvalid = out_valid_q;
    assign {m_tdata, m_tkeep, m_tlast, m_tuser} = out_pay_q;

endmodule

// File: rtl/eth_uplink_sched.sv
// eth_uplink_sched
// Frame-atomic scheduler sharing the 10G uplink TX stream between the
// control-plane source and the bulk data source. Whole frames are granted;
// control has priority, but after CTRL_BURST consecutive control frames with
// data waiting, a data frame is granted. Output goes through axis_skid_reg.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   s_ctrl_axis_*         control source stream (tready is backpressure)
//   s_data_axis_*         bulk data source stream (tready is backpressure)
//   m_tx_axis_*           registered stream to the MAC TX
//   o_grant               current owner: 0 none, 1 ctrl, 2 data
//   o_ctrl_frame_cnt      control frames forwarded, wraps at 16 bits
//   o_data_frame_cnt      data frames forwarded, wraps at 16 bits
module eth_uplink_sched
    import eth_pkg::*;
#(
    parameter int DATA_W     = ETH_DATA_W,
    parameter int KEEP_W     = ETH_KEEP_W,
    parameter int CTRL_BURST = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              s_ctrl_axis_tvalid,
    input  logic [DATA_W-1:0] s_ctrl_axis_tdata,
    input  logic              s_ctrl_axis_tlast,
    input  logic [KEEP_W-1:0] s_ctrl_axis_tkeep,
    input  logic              s_ctrl_axis_tuser,
    output logic              s_ctrl_axis_tready,
    input  logic              s_data_axis_tvalid,
    input  logic [DATA_W-1:0] s_data_axis_tdata,
    input  logic              s_data_axis_tlast,
    input  logic [KEEP_W-1:0] s_data_axis_tkeep,
    input  logic              s_data_axis_tuser,
    output logic              s_data_axis_tready,
    output logic              m_tx_axis_tvalid,
    output logic [DATA_W-1:0] m_tx_axis_tdata,
    output logic              m_tx_axis_tlast,
    output logic [KEEP_W-1:0] m_tx_axis_tkeep,
    output logic              m_tx_axis_tuser,
    input  logic              m_tx_axis_tready,
    output logic [1:0]        o_grant,
    output logic [15:0]       o_ctrl_frame_cnt,
    output logic [15:0]       o_data_frame_cnt
);

    localparam int                 BURST_W   = $clog2(CTRL_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(CTRL_BURST);

    grant_state_e       state_q, state_d;
    logic [BURST_W-1:0] burst_cnt_q;

    logic              skid_tvalid;
    logic [DATA_W-1:0] skid_tdata;
    logic [KEEP_W-1:0] skid_tkeep;
    logic              skid_tlast;
    logic              skid_tuser;
    logic              skid_tready;
    logic              frame_end;
    logic              ctrl_end;
    logic              data_end;

    // Route the owning source into the skid stage. The source that does not
    // own the link sees tready low, so it cannot lose a beat while waiting.
    always_comb begin
        skid_tvalid        = 1'b0;
        skid_tdata         = '0;
        skid_tkeep         = '0;
        skid_tlast         = 1'b0;
        skid_tuser         = 1'b0;
        s_ctrl_axis_tready = 1'b0;
        s_data_axis_tready = 1'b0;
        case (state_q)
            ST_CTRL: begin
                skid_tvalid        = s_ctrl_axis_tvalid;
                skid_tdata         = s_ctrl_axis_tdata;
                skid_tkeep         = s_ctrl_axis_tkeep;
                skid_tlast         = s_ctrl_axis_tlast;
                skid_tuser         = s_ctrl_axis_tuser;
                s_ctrl_axis_tready = skid_tready;
            end
            ST_DATA: begin
                skid_tvalid        = s_data_axis_tvalid;
                skid_tdata         = s_data_axis_tdata;
                skid_tkeep         = s_data_axis_tkeep;
                skid_tlast         = s_data_axis_tlast;
                skid_tuser         = s_data_axis_tuser;
                s_data_axis_tready = skid_tready;
            end
            default: ;
        endcase
    end

    assign frame_end = skid_tvalid & skid_tready & skid_tlast;
    assign ctrl_end  = frame_end & (state_q == ST_CTRL);
    assign data_end  = frame_end & (state_q == ST_DATA);

    // Arbitration happens only in IDLE, so a frame is never interrupted.
    // Control wins unless it has used up its burst while data is waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (s_ctrl_axis_tvalid &&
                    ((burst_cnt_q < BURST_MAX) || !s_data_axis_tvalid)) begin
                    state_d = ST_CTRL;
                end else if (s_data_axis_tvalid) begin
                    state_d = ST_DATA;
                end
            end
            ST_CTRL: if (ctrl_end) state_d = ST_IDLE;
            ST_DATA: if (data_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The burst count only matters while data is waiting, so it restarts
    // whenever the data source goes quiet in IDLE or a data frame completes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            burst_cnt_q <= '0;
        end else if (ctrl_end) begin
            if (burst_cnt_q != BURST_MAX) begin
                burst_cnt_q <= burst_cnt_q + BURST_W'(1);
            end
        end else if (data_end) begin
            burst_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && !s_data_axis_tvalid) begin
            burst_cnt_q <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ctrl_frame_cnt <= 16'd0;
            o_data_frame_cnt <= 16'd0;
        end else begin
            if (ctrl_end) o_ctrl_frame_cnt <= o_ctrl_frame_cnt + 16'd1;
            if (data_end) o_data_frame_cnt <= o_data_frame_cnt + 16'd1;
        end
    end

    assign o_grant = state_q;

    axis_skid_reg #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_skid (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .s_tvalid (skid_tvalid),
        .s_tdata  (skid_tdata),
        .s_tkeep  (skid_tkeep),
        .s_tlast  (skid_tlast),
        .s_tuser  (skid_tuser),
        .s_tready (skid_tready),
        .m_tvalid (m_tx_axis_tvalid),
        .m_tdata  (m_tx_axis_tdata),
        .m_tkeep  (m_tx_axis_tkeep),
        .m_tlast  (m_tx_axis_tlast),
        .m_tuser  (m_tx_axis_tuser),
        .m_tready (m_tx_axis_tready)
    );

endmodule

// File: tb/tb_eth_uplink_sched.sv
// tb_eth_uplink_sched
// Directed bench for eth_uplink_sched. Each beat carries a self-describing
// word {tag, source, frame index, beat index, 16'hC0DE}; tkeep and tuser are
// derived from the beat position, so expected output is known independently.
module tb_eth_uplink_sched;

    localparam int DW      = 64;
    localparam int KW      = 8;
    localparam int TIMEOUT = 2000;

    logic          clk;
    logic          rst_n;
    logic          s_ctrl_axis_tvalid, s_ctrl_axis_tlast, s_ctrl_axis_tuser;
    logic [DW-1:0] s_ctrl_axis_tdata;
    logic [KW-1:0] s_ctrl_axis_tkeep;
    logic          s_ctrl_axis_tready;
    logic          s_data_axis_tvalid, s_data_axis_tlast, s_data_axis_tuser;
    logic [DW-1:0] s_data_axis_tdata;
    logic [KW-1:0] s_data_axis_tkeep;
    logic          s_data_axis_tready;
    logic          m_tx_axis_tvalid, m_tx_axis_tlast, m_tx_axis_tuser;
    logic [DW-1:0] m_tx_axis_tdata;
    logic [KW-1:0] m_tx_axis_tkeep;
    logic          m_tx_axis_tready;
    logic [1:0]    o_grant;
    logic [15:0]   o_ctrl_frame_cnt, o_data_frame_cnt;

    int chk_cnt;
    int pass_cnt;

    int           ctrl_lens[$];
    int           data_lens[$];
    logic [DW-1:0] obs_data[$];
    logic          obs_last[$];
    logic [KW-1:0] obs_keep[$];
    logic          obs_user[$];
    int            obs_cyc[$];

    eth_uplink_sched #(
        .DATA_W     (DW),
        .KEEP_W     (KW),
        .CTRL_BURST (4)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .s_ctrl_axis_tvalid (s_ctrl_axis_tvalid),
        .s_ctrl_axis_tdata  (s_ctrl_axis_tdata),
        .s_ctrl_axis_tlast  (s_ctrl_axis_tlast),
        .s_ctrl_axis_tkeep  (s_ctrl_axis_tkeep),
        .s_ctrl_axis_tuser  (s_ctrl_axis_tuser),
        .s_ctrl_axis_tready (s_ctrl_axis_tready),
        .s_data_axis_tvalid (s_data_axis_tvalid),
        .s_data_axis_tdata  (s_data_axis_tdata),
        .s_data_axis_tlast  (s_data_axis_tlast),
        .s_data_axis_tkeep  (s_data_axis_tkeep),
        .s_data_axis_tuser  (s_data_axis_tuser),
        .s_data_axis_tready (s_data_axis_tready),
        .m_tx_axis_tvalid   (m_tx_axis_tvalid),
        .m_tx_axis_tdata    (m_tx_axis_tdata),
        .m_tx_axis_tlast    (m_tx_axis_tlast),
        .m_tx_axis_tkeep    (m_tx_axis_tkeep),
        .m_tx_axis_tuser    (m_tx_axis_tuser),
        .m_tx_axis_tready   (m_tx_axis_tready),
        .o_grant            (o_grant),
        .o_ctrl_frame_cnt   (o_ctrl_frame_cnt),
        .o_data_frame_cnt   (o_data_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] beat_word(input logic src, input int f, input int b);
        return {7'b1010000, src, 24'(f), 16'(b), 16'hC0DE};
    endfunction

    function automatic logic [KW-1:0] keep_of(input logic last);
        return last ? 8'h0F : 8'hFF;
    endfunction

    function automatic logic user_of(input logic src, input int b);
        return src ^ ((b % 2) == 1);
    endfunction

    function automatic logic [DW+KW+1:0] exp_beat(input logic src, input int f, input int b, input int len);
        logic last;
        last = (b == len - 1);
        return {beat_word(src, f, b), last, keep_of(last), user_of(src, b)};
    endfunction

    // Every bench action happens 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input logic is_ctrl, input logic v, input int f, input int b, input int len);
        logic [DW-1:0] w;
        logic          l;
        w = v ? beat_word(is_ctrl, f, b) : '0;
        l = v && (b == len - 1);
        if (is_ctrl) begin
            s_ctrl_axis_tvalid = v;
            s_ctrl_axis_tdata  = w;
            s_ctrl_axis_tlast  = l;
            s_ctrl_axis_tkeep  = v ? keep_of(l) : '0;
            s_ctrl_axis_tuser  = v ? user_of(is_ctrl, b) : 1'b0;
        end else begin
            s_data_axis_tvalid = v;
            s_data_axis_tdata  = w;
            s_data_axis_tlast  = l;
            s_data_axis_tkeep  = v ? keep_of(l) : '0;
            s_data_axis_tuser  = v ? user_of(is_ctrl, b) : 1'b0;
        end
    endtask

    // Leaves the bench at the start of cycle 0 with reset just released.
    task automatic do_reset();
        rst_n = 1'b0;
        set_src(1'b1, 1'b0, 0, 0, 1);
        set_src(1'b0, 1'b0, 0, 0, 1);
        m_tx_axis_tready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic drive_src(input logic is_ctrl, input int nframes, input int fixed_len,
                             input int max_gap, input int start_delay);
        int   len;
        int   waitc;
        logic rdy;
        repeat (start_delay) step();
        for (int f = 0; f < nframes; f++) begin
            len = (fixed_len > 0) ? fixed_len : (is_ctrl ? ctrl_lens[f] : data_lens[f]);
            for (int b = 0; b < len; b++) begin
                set_src(is_ctrl, 1'b1, f, b, len);
                waitc = 0;
                forever begin
                    rdy = is_ctrl ? s_ctrl_axis_tready : s_data_axis_tready;
                    step();
                    if (rdy === 1'b1) break;
                    waitc++;
                    if (waitc > TIMEOUT) begin
                        chk_cnt++;
                        $display("[TB] FAIL src_timeout src=%0d frame=%0d beat=%0d got no tready, required tready within %0d cycles",
                                 is_ctrl, f, b, TIMEOUT);
                        set_src(is_ctrl, 1'b0, 0, 0, 1);
                        return;
                    end
                end
            end
            set_src(is_ctrl, 1'b0, 0, 0, 1);
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) step();
        end
    endtask

    // Collects transferred beats and checks that a stalled beat holds still.
    task automatic monitor(input int nframes, input int ready_pct, input int budget);
        int            frames;
        int            cyc;
        logic          pv, pr, pl;
        logic [DW-1:0] pd;
        frames = 0;
        cyc    = 0;
        pv     = 1'b0;
        pr     = 1'b0;
        pl     = 1'b0;
        pd     = '0;
        obs_data.delete(); obs_last.delete(); obs_keep.delete();
        obs_user.delete(); obs_cyc.delete();
        while (frames < nframes && cyc < budget) begin
            m_tx_axis_tready = ($urandom_range(99, 0) < ready_pct);
            if (pv && !pr) begin
                chk_cnt++;
                if ({m_tx_axis_tvalid, m_tx_axis_tdata, m_tx_axis_tlast} !== {1'b1, pd, pl}) begin
                    $display("[TB] FAIL stall_hold cyc=%0d got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                             cyc, m_tx_axis_tvalid, m_tx_axis_tdata, m_tx_axis_tlast, pd, pl);
                end else begin
                    pass_cnt++;
                end
            end
            if (m_tx_axis_tvalid === 1'b1 && m_tx_axis_tready) begin
                obs_data.push_back(m_tx_axis_tdata);
                obs_last.push_back(m_tx_axis_tlast);
                obs_keep.push_back(m_tx_axis_tkeep);
                obs_user.push_back(m_tx_axis_tuser);
                obs_cyc.push_back(cyc);
                if (m_tx_axis_tlast) frames++;
            end
            pv = m_tx_axis_tvalid;
            pr = m_tx_axis_tready;
            pd = m_tx_axis_tdata;
            pl = m_tx_axis_tlast;
            step();
            cyc++;
        end
        if (frames < nframes) begin
            chk_cnt++;
            $display("[TB] FAIL monitor_timeout got %0d frames, required %0d", frames, nframes);
        end
        m_tx_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_src(1'b1, 1'b1, 0, 0, 2);
        set_src(1'b0, 1'b1, 0, 0, 2);
        m_tx_axis_tready = 1'b1;
        repeat (3) step();
        chk_cnt++;
        if ({m_tx_axis_tvalid, m_tx_axis_tdata, m_tx_axis_tlast, m_tx_axis_tkeep, m_tx_axis_tuser} !== '0) begin
            $display("[TB] FAIL reset_m_tx got v=%b d=%h l=%b k=%h u=%b, required all 0",
                     m_tx_axis_tvalid, m_tx_axis_tdata, m_tx_axis_tlast, m_tx_axis_tkeep, m_tx_axis_tuser);
        end else pass_cnt++;
        chk_cnt++;
        if ({s_ctrl_axis_tready, s_data_axis_tready, o_grant} !== 4'b0000) begin
            $display("[TB] FAIL reset_ready_grant got ctrl_rdy=%b data_rdy=%b grant=%0d, required 0 0 0",
                     s_ctrl_axis_tready, s_data_axis_tready, o_grant);
        end else pass_cnt++;
        chk_cnt++;
        if ({o_ctrl_frame_cnt, o_data_frame_cnt} !== 32'h0) begin
            $display("[TB] FAIL reset_counters got ctrl=%h data=%h, required 0000 0000",
                     o_ctrl_frame_cnt, o_data_frame_cnt);
        end else pass_cnt++;
        set_src(1'b1, 1'b0, 0, 0, 1);
        set_src(1'b0, 1'b0, 0, 0, 1);
    endtask

    task automatic test_single_data();
        int b;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            b = (c <= 1) ? 0 : c - 1;
            set_src(1'b0, (b <= 4), 0, b, 5);
            if (c == 0) begin
                chk_cnt++;
                if (o_grant !== 2'd0) $display("[TB] FAIL single_grant_c0 got %0d, required 0", o_grant);
                else pass_cnt++;
            end
            if (c == 1) begin
                chk_cnt++;
                if ({o_grant, s_data_axis_tready, s_ctrl_axis_tready} !== {2'd2, 1'b1, 1'b0}) begin
                    $display("[TB] FAIL single_grant_c1 got grant=%0d data_rdy=%b ctrl_rdy=%b, required 2 1 0",
                             o_grant, s_data_axis_tready, s_ctrl_axis_tready);
                end else pass_cnt++;
            end
            if (c >= 2 && c <= 6) begin
                chk_cnt++;
                if ({m_tx_axis_tvalid, m_tx_axis_tdata, m_tx_axis_tlast, m_tx_axis_tkeep, m_tx_axis_tuser}
                    !== {1'b1, exp_beat(1'b0, 0, c - 2, 5)}) begin
                    $display("[TB] FAIL single_beat%0d got v=%b d=%h l=%b k=%h u=%b, required v=1 %h",
                             c - 2, m_tx_axis_tvalid, m_tx_axis_tdata, m_tx_axis_tlast, m_tx_axis_tkeep,
                             m_tx_axis_tuser, exp_beat(1'b0, 0, c - 2, 5));
                end else pass_cnt++;
                chk_cnt++;
                if (s_ctrl_axis_tready !== 1'b0) $display("[TB] FAIL single_ctrl_rdy cyc=%0d got %b, required 0", c, s_ctrl_axis_tready);
                else pass_cnt++;
            end
            if (c == 6) begin
                chk_cnt++;
                if ({o_data_frame_cnt, o_ctrl_frame_cnt, o_grant} !== {16'd1, 16'd0, 2'd0}) begin
                    $display("[TB] FAIL single_counts got data=%0d ctrl=%0d grant=%0d, required 1 0 0",
                             o_data_frame_cnt, o_ctrl_frame_cnt, o_grant);
                end else pass_cnt++;
            end
            if (c == 7) begin
                chk_cnt++;
                if (m_tx_axis_tvalid !== 1'b0) $display("[TB] FAIL single_drain got tvalid=%b, required 0", m_tx_axis_tvalid);
                else pass_cnt++;
            end
            step();
        end
    endtask

    task automatic test_burst_pattern();
        logic [12:0] exp_seq;
        logic [12:0] seq;
        int          nseq;
        int          w;
        logic [15:0] ctrl_at;
        exp_seq = 13'b1111011110110;
        seq     = '0;
        nseq    = 0;
        ctrl_at = 16'hDEAD;
        do_reset();
        fork
            drive_src(1'b1, 10, 3, 0, 0);
            drive_src(1'b0, 3, 3, 0, 0);
            monitor(13, 100, 1000);
            begin
                w = 0;
                while (o_data_frame_cnt !== 16'd2 && w < 1000) begin
                    step();
                    w++;
                end
                ctrl_at = o_ctrl_frame_cnt;
            end
        join
        for (int i = 0; i < obs_data.size(); i++) begin
            if (obs_last[i] && nseq < 13) begin
                seq[12 - nseq] = obs_data[i][56];
                nseq++;
            end
        end
        chk_cnt++;
        if (seq !== exp_seq) $display("[TB] FAIL burst_order got %b, required %b (1=ctrl)", seq, exp_seq);
        else pass_cnt++;
        chk_cnt++;
        if (ctrl_at !== 16'd8) $display("[TB] FAIL burst_ctrl_at_data2 got %0d, required 8", ctrl_at);
        else pass_cnt++;
        chk_cnt++;
        if ({o_ctrl_frame_cnt, o_data_frame_cnt} !== {16'd10, 16'd3}) begin
            $display("[TB] FAIL burst_totals got ctrl=%0d data=%0d, required 10 3", o_ctrl_frame_cnt, o_data_frame_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_ctrl_mid_data();
        do_reset();
        fork
            drive_src(1'b0, 1, 6, 0, 0);
            drive_src(1'b1, 1, 2, 0, 3);
            monitor(2, 100, 200);
        join
        chk_cnt++;
        if (obs_data.size() !== 8) $display("[TB] FAIL mid_beat_count got %0d, required 8", obs_data.size());
        else pass_cnt++;
        if (obs_data.size() == 8) begin
            for (int i = 0; i < 7; i++) begin
                chk_cnt++;
                if ({obs_data[i], obs_last[i]} !== ((i < 6) ? {beat_word(1'b0, 0, i), (i == 5)}
                                                            : {beat_word(1'b1, 0, 0), 1'b0})) begin
                    $display("[TB] FAIL mid_beat%0d got d=%h l=%b, required %s", i, obs_data[i], obs_last[i],
                             (i < 6) ? "data frame beat in order" : "ctrl beat 0");
                end else pass_cnt++;
            end
            chk_cnt++;
            if ({obs_cyc[5], obs_cyc[6]} !== {32'd7, 32'd9}) begin
                $display("[TB] FAIL mid_timing got data_last_cyc=%0d ctrl_first_cyc=%0d, required 7 9",
                         obs_cyc[5], obs_cyc[6]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_random_backpressure();
        int            nf[2];
        bit            in_frame;
        bit            bad;
        int            src, f, b, len;
        logic [DW+KW+1:0] got;
        ctrl_lens.delete();
        data_lens.delete();
        for (int i = 0; i < 100; i++) begin
            ctrl_lens.push_back($urandom_range(4, 1));
            data_lens.push_back($urandom_range(4, 1));
        end
        do_reset();
        fork
            drive_src(1'b1, 100, 0, 2, 0);
            drive_src(1'b0, 100, 0, 2, 0);
            monitor(200, 50, 20000);
        join
        nf[0]    = 0;
        nf[1]    = 0;
        in_frame = 1'b0;
        bad      = 1'b0;
        src = 0; f = 0; b = 0; len = 1;
        for (int i = 0; i < obs_data.size() && !bad; i++) begin
            if (!in_frame) begin
                src = obs_data[i][56] ? 1 : 0;
                f   = nf[src];
                b   = 0;
                len = (f < 100) ? (src == 1 ? ctrl_lens[f] : data_lens[f]) : 0;
            end else begin
                b++;
            end
            got = {obs_data[i], obs_last[i], obs_keep[i], obs_user[i]};
            chk_cnt++;
            if (got !== exp_beat(src[0], f, b, len)) begin
                $display("[TB] FAIL rand_beat%0d got %h, required %h", i, got, exp_beat(src[0], f, b, len));
                bad = 1'b1;
            end else pass_cnt++;
            in_frame = !obs_last[i];
            if (obs_last[i]) nf[src]++;
        end
        chk_cnt++;
        if (nf[0] !== 100 || nf[1] !== 100) begin
            $display("[TB] FAIL rand_frames got data=%0d ctrl=%0d, required 100 100", nf[0], nf[1]);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        set_src(1'b0, 1'b1, 0, 0, 1);
        step();
        step();
        set_src(1'b0, 1'b0, 0, 0, 1);
        set_src(1'b1, 1'b1, 0, 0, 7);
        step();
        step();
        set_src(1'b1, 1'b1, 0, 1, 7);
        step();
        set_src(1'b1, 1'b1, 0, 2, 7);
        chk_cnt++;
        if ({o_grant, o_data_frame_cnt, m_tx_axis_tvalid, m_tx_axis_tdata} !== {2'd1, 16'd1, 1'b1, beat_word(1'b1, 0, 1)}) begin
            $display("[TB] FAIL rmid_pre got grant=%0d data_cnt=%0d v=%b d=%h, required 1 1 1 %h",
                     o_grant, o_data_frame_cnt, m_tx_axis_tvalid, m_tx_axis_tdata, beat_word(1'b1, 0, 1));
        end else pass_cnt++;
        rst_n = 1'b0;
        step();
        chk_cnt++;
        if ({m_tx_axis_tvalid, s_ctrl_axis_tready, s_data_axis_tready, o_grant, o_ctrl_frame_cnt, o_data_frame_cnt}
            !== '0) begin
            $display("[TB] FAIL rmid_reset got v=%b crdy=%b drdy=%b grant=%0d ccnt=%0d dcnt=%0d, required all 0",
                     m_tx_axis_tvalid, s_ctrl_axis_tready, s_data_axis_tready, o_grant,
                     o_ctrl_frame_cnt, o_data_frame_cnt);
        end else pass_cnt++;
        set_src(1'b1, 1'b0, 0, 0, 1);
        step();
        rst_n = 1'b1;
        fork
            drive_src(1'b0, 1, 3, 0, 0);
            monitor(1, 100, 100);
        join
        chk_cnt++;
        if (obs_data.size() !== 3) $display("[TB] FAIL rmid_after_count got %0d beats, required 3", obs_data.size());
        else pass_cnt++;
        if (obs_data.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk_cnt++;
                if ({obs_data[i], obs_last[i]} !== {beat_word(1'b0, 0, i), (i == 2)}) begin
                    $display("[TB] FAIL rmid_after_beat%0d got d=%h l=%b, required d=%h l=%b",
                             i, obs_data[i], obs_last[i], beat_word(1'b0, 0, i), (i == 2));
                end else pass_cnt++;
            end
        end
        chk_cnt++;
        if ({o_data_frame_cnt, o_ctrl_frame_cnt} !== {16'd1, 16'd0}) begin
            $display("[TB] FAIL rmid_after_counts got data=%0d ctrl=%0d, required 1 0", o_data_frame_cnt, o_ctrl_frame_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_counter_wrap();
        do_reset();
        drive_src(1'b0, 65535, 1, 0, 0);
        chk_cnt++;
        if (o_data_frame_cnt !== 16'hFFFF) $display("[TB] FAIL wrap_ffff got %h, required ffff", o_data_frame_cnt);
        else pass_cnt++;
        drive_src(1'b0, 1, 1, 0, 0);
        step();
        chk_cnt++;
        if ({o_data_frame_cnt, o_ctrl_frame_cnt} !== 32'h0) begin
            $display("[TB] FAIL wrap_zero got data=%h ctrl=%h, required 0000 0000", o_data_frame_cnt, o_ctrl_frame_cnt);
        end else pass_cnt++;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        $display("[TB] starting eth_uplink_sched bench");
        test_reset();
        test_single_data();
        test_burst_pattern();
        test_ctrl_mid_data();
        test_random_backpressure();
        test_reset_mid_frame();
        test_counter_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/eth_uplink_sched.md
# eth_uplink_sched

Frame-atomic scheduler sharing the 10G uplink TX AXI-Stream between the control-plane stream and the bulk data stream. Grants a whole frame at a time: control gets priority, and a burst limit guarantees the data stream forward progress. It sits between the control/data source FIFOs and the 10G MAC TX interface, and drives the MAC through a registered skid stage.

## Interface
Parameters:
- DATA_W, 64, tdata width
- KEEP_W, 8, tkeep width (DATA_W/8)
- CTRL_BURST, 4, max consecutive control frames granted while data is waiting (≥1)

Ports:
- i_clk  in  1  single clock for the whole block
- i_rst_n  in  1  asynchronous, active-low reset
- s_ctrl_axis_tvalid/tdata/tlast/tkeep/tuser  in  1/DATA_W/1/KEEP_W/1  control source stream
- s_ctrl_axis_tready  out  1  control source backpressure
- s_data_axis_tvalid/tdata/tlast/tkeep/tuser  in  1/DATA_W/1/KEEP_W/1  data source stream
- s_data_axis_tready  out  1  data source backpressure
- m_tx_axis_tvalid/tdata/tlast/tkeep/tuser  out  1/DATA_W/1/KEEP_W/1  to MAC TX
- m_tx_axis_tready  in  1  MAC backpressure
- o_grant  out  2  current owner: 0 none, 1 ctrl, 2 data
- o_ctrl_frame_cnt  out  16  control frames forwarded (wraps)
- o_data_frame_cnt  out  16  data frames forwarded (wraps)

## Operation
- FSM states are IDLE, CTRL and DATA; o_grant is the state encoding.
- IDLE transitions:
  - to CTRL if ctrl tvalid and (burst_cnt < CTRL_BURST, or data tvalid is low);
  - otherwise to DATA if data tvalid;
  - otherwise stay in IDLE.
- CTRL/DATA: the selected source passes through to the skid stage. Selected tready = skid s_tready; the unselected source's tready = 0.
- A frame ends on an accepted beat (tvalid & tready) with tlast = 1. On that beat the state returns to IDLE, with no re-arbitration inside a frame.
- burst_cnt (width $clog2(CTRL_BURST+1)):
  - +1 on each ctrl frame end, saturating at CTRL_BURST;
  - cleared on each data frame end;
  - cleared on any IDLE cycle in which data tvalid is low.
- Frame counters: +1 on the respective frame end, 16-bit wrap (0xFFFF → 0x0000).
- tuser is forwarded unchanged for both sources.
- Simultaneous requests in IDLE follow the priority/burst rule above. A ctrl request arriving mid-data-frame waits for that frame's tlast.
- Zero-length frames do not exist: every frame has at least one beat.
- Reset (any time, including mid-frame):
  - state IDLE, burst_cnt 0, counters 0, skid emptied;
  - all m_tx_axis_* 0 except tkeep 0;
  - both s_*_tready 0, o_grant 0.
- Frame content lost by a mid-frame reset is the upstream's responsibility.

## Timing
- Arbitration: an IDLE cycle n with a request registers the grant at n+1. The first beat can be accepted at n+1 and appears on m_tx at n+2 if m_tx_axis_tready is high.
- Throughput inside a frame is one beat per cycle with tready held high.
- Inter-frame gap: tlast accepted at cycle k → IDLE at k+1 → next frame's first beat accepted at k+2 at the earliest. That is one idle input cycle per frame.
- Skid stage:
  - s_tready is registered, equal to not-full;
  - m_tx_axis_tvalid/data are registered;
  - no combinational path from m_tx_axis_tready to s_*_tready;
  - data and tlast are held stable while m_tx_axis_tvalid and not tready.
- Counters and o_grant update on the clock edge after the triggering event.

## Structure
- Shared package (eth_pkg): the grant-state encoding constants (GRANT_NONE=0, GRANT_CTRL=1, GRANT_DATA=2) and the DATA_W/KEEP_W defaults, so the uplink port and the MAC glue agree on them.
- One sub-module, axis_skid_reg: a 2-entry AXIS register slice carrying data, keep, last and user. It is full-throughput and has an asynchronous active-low reset.
- The FSM, burst counter, muxing and frame counters live in eth_uplink_sched.

## Test plan
- Single data frame of 5 beats, tready always 1, ctrl idle → o_grant=2 from cycle 1, 5 beats out on cycles 2–6 with tlast on beat 5, o_data_frame_cnt=1, ctrl tready stays 0.
- Ctrl and data both valid from reset release, CTRL_BURST=4, endless 3-beat frames on both → ctrl, ctrl, ctrl, ctrl, data, ctrl… pattern; o_ctrl_frame_cnt=8 when o_data_frame_cnt=2.
- Ctrl valid during beat 2 of a 6-beat data frame → data frame completes intact (6 beats, no interleave), ctrl frame starts 2 cycles after data tlast acceptance.
- Random m_tx_axis_tready (50%) over 200 mixed frames → output beat sequence equals the expected frame-ordered concatenation, with no beat lost or duplicated and data stable while stalled.
- i_rst_n asserted on beat 3 of a 7-beat ctrl frame → next cycle m_tx_axis_tvalid=0, both tready=0, counters 0, o_grant=0; after release a fresh data frame forwards normally.
- 65 536 one-beat data frames → o_data_frame_cnt wraps to 0x0000, o_ctrl_frame_cnt stays 0.
